// File: rtl/rr_grant_scheduler.sv
// Round-robin scheduler: registered one-hot grant, one idle cycle between owners.
// Define ARB_TIMEOUT_EN to revoke a grant after MAX_HOLD cycles while others wait.
module rr_grant_scheduler #(
    parameter int NREQ     = 4,
    parameter int IDW      = 2,
    parameter int MAX_HOLD = 8
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic            gnt_valid,
    output logic [IDW-1:0]  gnt_id,
    output logic            busy,
    output logic            timeout_evt
);

    if (NREQ < 2 || NREQ > 8 || (1 << IDW) < NREQ || MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_param
        $error("rr_grant_scheduler: illegal parameter set");
    end

    typedef enum logic [2:0] {
        S_IDLE    = 3'b001,
        S_GRANT   = 3'b010,
        S_RELEASE = 3'b100
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [NREQ-1:0] r_gnt;
    logic [NREQ-1:0] w_gnt_nxt;
    logic [IDW-1:0]  r_gnt_id;
    logic [IDW-1:0]  w_gnt_id_nxt;
    logic [IDW-1:0]  r_ptr;
    logic [IDW-1:0]  w_ptr_nxt;

    logic            w_any_req;
    logic            w_owner_req;
    logic [IDW-1:0]  w_pick;
    logic [NREQ-1:0] w_pick_onehot;
    logic [IDW-1:0]  w_next_ptr;

`ifdef ARB_TIMEOUT_EN
    logic [7:0]      r_hold_cnt;
    logic [7:0]      w_hold_cnt_nxt;
    logic            r_tevt;
    logic            w_tevt_nxt;
    logic            w_others_req;
    logic            w_hold_max;
`endif

    // First requester at or after ptr, wrapping modulo NREQ.
    function automatic logic [IDW-1:0] f_rr_pick(input logic [NREQ-1:0] req_v,
                                                 input logic [IDW-1:0]  ptr_v);
        logic [IDW-1:0] win;
        int             idx;
        win = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(ptr_v) + k) % NREQ;
            if (req_v[idx]) win = IDW'(idx);
        end
        return win;
    endfunction

    assign w_any_req     = |req;
    assign w_owner_req   = |(req & r_gnt);
    assign w_pick        = f_rr_pick(req, r_ptr);
    assign w_pick_onehot = NREQ'(1) << w_pick;
    assign w_next_ptr    = IDW'((int'(r_gnt_id) + 1) % NREQ);

`ifdef ARB_TIMEOUT_EN
    assign w_others_req  = |(req & ~r_gnt);
    assign w_hold_max    = (r_hold_cnt == 8'(MAX_HOLD - 1));
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_gnt      <= '0;
            r_gnt_id   <= '0;
            r_ptr      <= '0;
`ifdef ARB_TIMEOUT_EN
            r_hold_cnt <= '0;
            r_tevt     <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_gnt      <= w_gnt_nxt;
            r_gnt_id   <= w_gnt_id_nxt;
            r_ptr      <= w_ptr_nxt;
`ifdef ARB_TIMEOUT_EN
            r_hold_cnt <= w_hold_cnt_nxt;
            r_tevt     <= w_tevt_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_gnt_nxt      = r_gnt;
        w_gnt_id_nxt   = r_gnt_id;
        w_ptr_nxt      = r_ptr;
`ifdef ARB_TIMEOUT_EN
        w_hold_cnt_nxt = r_hold_cnt;
        w_tevt_nxt     = 1'b0;
`endif
        case (r_state)
            // RELEASE selects exactly like IDLE, but with the ptr just advanced.
            S_IDLE, S_RELEASE: begin
                if (w_any_req) begin
                    w_state_nxt    = S_GRANT;
                    w_gnt_nxt      = w_pick_onehot;
                    w_gnt_id_nxt   = w_pick;
`ifdef ARB_TIMEOUT_EN
                    w_hold_cnt_nxt = '0;
`endif
                end else begin
                    w_state_nxt    = S_IDLE;
                    w_gnt_nxt      = '0;
                end
            end
            S_GRANT: begin
                if (!w_owner_req) begin
                    w_state_nxt = S_RELEASE;
                    w_gnt_nxt   = '0;
                    w_ptr_nxt   = w_next_ptr;
                end
`ifdef ARB_TIMEOUT_EN
                else if (w_hold_max && w_others_req) begin
                    w_state_nxt = S_RELEASE;
                    w_gnt_nxt   = '0;
                    w_ptr_nxt   = w_next_ptr;
                    w_tevt_nxt  = 1'b1;
                end else if (!w_hold_max) begin
                    w_hold_cnt_nxt = r_hold_cnt + 8'd1;
                end
`endif
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_gnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        gnt         = r_gnt;
        gnt_valid   = |r_gnt;
        gnt_id      = r_gnt_id;
        busy        = (r_state != S_IDLE);
`ifdef ARB_TIMEOUT_EN
        timeout_evt = r_tevt;
`else
        timeout_evt = 1'b0;
`endif
    end

endmodule

// File: tb/tb_rr_grant_scheduler.sv
// Randomised and directed bench for rr_grant_scheduler against an owner/hold-count reference model.
module tb_rr_grant_scheduler;
    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int MH   = 4;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic            clock   = 1'b0;
    logic            reset_n = 1'b1;
    logic [NREQ-1:0] req     = '0;
    logic [NREQ-1:0] gnt;
    logic            gnt_valid;
    logic [IDW-1:0]  gnt_id;
    logic            busy;
    logic            timeout_evt;

    always #5 clock = ~clock;

    rr_grant_scheduler #(.NREQ(NREQ), .IDW(IDW), .MAX_HOLD(MH)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .req         (req),
        .gnt         (gnt),
        .gnt_valid   (gnt_valid),
        .gnt_id      (gnt_id),
        .busy        (busy),
        .timeout_evt (timeout_evt)
    );

    int n_vec = 0;
    int n_mis = 0;

    // Reference model: who owns the resource, for how long, and where the scan starts.
    int m_owner;
    int m_ptr;
    int m_last;
    int m_held;
    bit m_gap;
    bit m_tevt;
    int grant_log[$];

    int obs_tevt;
    int obs_g0;
    int obs_g1;

    int exp_a[5] = '{0, 1, 2, 3, 0};
    int exp_b[3] = '{3, 0, 1};
    logic [NREQ-1:0] rnd_req;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s @%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic mdl_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_last  = 0;
        m_held  = 0;
        m_gap   = 1'b0;
        m_tevt  = 1'b0;
    endtask

    task automatic mdl_edge(input logic [NREQ-1:0] r);
        bit drop;
        m_tevt = 1'b0;
        if (m_owner >= 0) begin
            drop = !r[m_owner];
            if (!drop && TO_EN && m_held >= MH && (r & ~(4'b0001 << m_owner)) != 4'b0000) begin
                drop   = 1'b1;
                m_tevt = 1'b1;
            end
            if (drop) begin
                m_ptr   = (m_owner + 1) % NREQ;
                m_owner = -1;
                m_gap   = 1'b1;
            end else begin
                m_held++;
            end
        end else begin
            m_gap   = 1'b0;
            m_owner = rr_pick(r, m_ptr);
            if (m_owner >= 0) begin
                m_last = m_owner;
                m_held = 1;
                grant_log.push_back(m_owner);
            end
        end
    endtask

    task automatic check_outputs();
        logic [NREQ-1:0] eg;
        eg = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
        check_eq("gnt",         32'(gnt),         32'(eg));
        check_eq("gnt_valid",   32'(gnt_valid),   32'(m_owner >= 0));
        check_eq("gnt_id",      32'(gnt_id),      32'(m_last));
        check_eq("busy",        32'(busy),        32'((m_owner >= 0) || m_gap));
        check_eq("timeout_evt", 32'(timeout_evt), 32'(m_tevt));
    endtask

    // Called at a falling edge; drives req, lets one rising edge pass, checks just after it.
    task automatic step(input logic [NREQ-1:0] r);
        req = r;
        @(posedge clock);
        mdl_edge(r);
        #1;
        check_outputs();
        if (timeout_evt) obs_tevt++;
        if (gnt == 4'b0001) obs_g0++;
        if (gnt == 4'b0010) obs_g1++;
        @(negedge clock);
    endtask

    task automatic do_reset();
        req     = '0;
        reset_n = 1'b0;
        #1;
        mdl_reset();
        check_outputs();
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        grant_log.delete();
        obs_tevt = 0;
        obs_g0   = 0;
        obs_g1   = 0;
    endtask

    // Reset pulse landing between clock edges; outputs must clear before any edge.
    task automatic mid_reset();
        #2;
        reset_n = 1'b0;
        #1;
        mdl_reset();
        check_outputs();
        @(negedge clock);
        reset_n = 1'b1;
        grant_log.delete();
    endtask

    // Holds base pattern; the current owner lowers its bit once it has held for 'hold' cycles.
    task automatic run_drop(input logic [NREQ-1:0] base, input int hold, input int ncyc);
        logic [NREQ-1:0] r;
        for (int c = 0; c < ncyc; c++) begin
            r = base;
            if (m_owner >= 0 && m_held >= hold) r[m_owner] = 1'b0;
            step(r);
        end
    endtask

    initial begin
        #2;
        // Idle with no requests
        do_reset();
        for (int c = 0; c < 10; c++) step(4'b0000);

        // Full contention, owners drop after 3 cycles
        do_reset();
        run_drop(4'b1111, 3, 19);
        check_eq("order_a_len", 32'(grant_log.size()), 32'd5);
        for (int i = 0; i < 5; i++)
            check_eq("order_a", 32'((i < grant_log.size()) ? grant_log[i] : -1), 32'(exp_a[i]));

        // ptr lands on 2 after owner 1, then 1011 is served 3,0,1
        do_reset();
        run_drop(4'b0010, 2, 3);
        grant_log.delete();
        run_drop(4'b1011, 2, 9);
        check_eq("order_b_len", 32'(grant_log.size()), 32'd3);
        for (int i = 0; i < 3; i++)
            check_eq("order_b", 32'((i < grant_log.size()) ? grant_log[i] : -1), 32'(exp_b[i]));

        // Asynchronous reset while requester 2 owns the grant
        do_reset();
        step(4'b0100);
        step(4'b0100);
        check_eq("pre_reset_gnt", 32'(gnt), 32'h4);
        mid_reset();
        step(4'b1100);
        check_eq("post_reset_gnt", 32'(gnt), 32'h4);
        step(4'b1100);

        // Two-way contention: timeout splits it 4/4, otherwise owner 0 keeps it
        do_reset();
        for (int c = 0; c < 9; c++) step(4'b0011);
        check_eq("hold_g0",   32'(obs_g0),   TO_EN ? 32'd4 : 32'd9);
        check_eq("hold_g1",   32'(obs_g1),   TO_EN ? 32'd4 : 32'd0);
        check_eq("tevt_cnt",  32'(obs_tevt), TO_EN ? 32'd1 : 32'd0);

        // Single requester never times out
        do_reset();
        for (int c = 0; c < 20; c++) step(4'b0001);
        check_eq("solo_g0",   32'(obs_g0),   32'd20);
        check_eq("solo_tevt", 32'(obs_tevt), 32'd0);

        // Random request traffic with one asynchronous reset in the middle
        do_reset();
        rnd_req = '0;
        for (int c = 0; c < 400; c++) begin
            for (int b = 0; b < NREQ; b++) begin
                if (rnd_req[b]) begin
                    if ($urandom_range(5) == 0) rnd_req[b] = 1'b0;
                end else if ($urandom_range(3) == 0) begin
                    rnd_req[b] = 1'b1;
                end
            end
            step(rnd_req);
            if (c == 200) mid_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
